dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single data cache request/response port between two requesters: requester 0 is the pipeline memory stage and requester 1 is the page-table walker / debug access path.
- Arbitrates requests with round-robin priority and records the owner of each accepted request in an in-order ID FIFO.
- Routes each completion (response or exception) back to the requester that issued it.
- Sits between the requesters and the dcache request/response interface.

Parameters:
- ReqWidth, 200: width of the packed request payload (address, value, op, size, size_ext, amo, prv, sum, mxr, atp), passed through unmodified.
- MaxOutstanding, 4: ID FIFO depth; the maximum number of accepted but uncompleted requests (power of two, at least 2).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- req0_valid_i  in  1  requester 0 request valid
- req0_ready_o  out  1  requester 0 request accepted
- req0_payload_i  in  ReqWidth  requester 0 request payload
- req1_valid_i  in  1  requester 1 request valid
- req1_ready_o  out  1  requester 1 request accepted
- req1_payload_i  in  ReqWidth  requester 1 request payload
- resp0_valid_o  out  1  requester 0 response pulse
- resp1_valid_o  out  1  requester 1 response pulse
- ex0_valid_o  out  1  requester 0 exception pulse
- ex1_valid_o  out  1  requester 1 exception pulse
- dc_req_valid_o  out  1  downstream request valid
- dc_req_ready_i  in  1  downstream request ready
- dc_req_payload_o  out  ReqWidth  downstream request payload
- dc_resp_valid_i  in  1  downstream response valid (no backpressure)
- dc_ex_valid_i  in  1  downstream exception valid (no backpressure)
- outstanding_o  out  $clog2(MaxOutstanding)+1  count of in-flight requests
- err_o  out  1  sticky protocol error flag

Behaviour:
- Reset (async assert, sync release): FIFO empty, outstanding_o=0, err_o=0, round-robin pointer favours requester 0, no grant lock held. All outputs are 0 in reset.
- Downstream response/value data is fanned out by the parent; this block produces only the per-requester valid pulses.
- Grant selection, when no lock is held: if only one requester is valid, it wins. If both are valid, the one favoured by the RR pointer wins.
- Lock: once dc_req_valid_o is high without dc_req_ready_i, the winner is locked until its handshake completes, even if the other requester has priority. Requesters must hold valid and payload stable until ready. Dropping valid while locked sets err_o and releases the lock.
- RR pointer: on every accepted handshake it flips to favour the requester that was not just served.
- dc_req_valid_o = (winner valid) && !fifo_full. dc_req_payload_o = winner payload (combinational mux).
- reqN_ready_o = (grant==N) && dc_req_ready_i && !fifo_full. The non-granted requester's ready is always 0.
- Handshake (dc_req_valid_o && dc_req_ready_i): push the winner ID into the FIFO. Zero added latency on the request path.
- Completion is dc_resp_valid_i or dc_ex_valid_i. Each accepted request produces exactly one completion, in order.
  - On a completion, pop the FIFO head and assert resp/ex for the head ID in the same cycle (combinational).
- Both dc_resp_valid_i and dc_ex_valid_i high in one cycle: exception wins; the head is popped once; err_o is set.
- Completion while the FIFO is empty: no pulse to either requester, no pop, err_o set.
- Push and pop in the same cycle: count unchanged, pointers both advance.
- When full, no push is permitted, even if a pop occurs that cycle. There is no ready path from completion to request.
- A completion in the same cycle as its own acceptance is not supported; the downstream guarantees a latency of at least 1 cycle.
- Pointers wrap modulo MaxOutstanding. Full is tracked by count (count==MaxOutstanding), not pointer equality alone.
- Reset mid-operation: in-flight IDs are discarded. Completions arriving after reset with an empty FIFO set err_o.
- err_o stays high until reset.

Test Plan:
- Single requester: req0 valid, dc_req_ready_i=1, resp after 2 cycles -> req0_ready_o=1 in cycle 0; resp0_valid_o=1 in cycle 2; outstanding_o goes 0->1->0; resp1_valid_o never asserts.
- Contention: both requesters valid continuously, ready=1, responses after 1 cycle -> grants alternate 0,1,0,1 and response pulses alternate in the same order.
- Backpressure lock: req1 granted, ready=0 for 3 cycles, req0 asserted in cycle 1 -> payload stays req1 for all 3 cycles; req1 is accepted when ready rises; req0 is accepted next.
- Full: MaxOutstanding=4, 4 accepts with no completion -> outstanding_o=4 and dc_req_valid_o=0 on the 5th request; one resp pops and the 5th is accepted the following cycle.
- Exception routing: issue ids 1,0 then ex_valid, then resp_valid -> ex1_valid_o pulses, then resp0_valid_o pulses; err_o stays 0.
- Errors: resp_valid with an empty FIFO -> err_o=1 and no resp pulses. resp_valid and ex_valid together with head id 0 -> ex0_valid_o=1, err_o=1. Then assert rst_i mid-stream -> outstanding_o=0 and err_o=0 immediately.

Source files
------------

// File: rtl/dcache_port_arbiter_if.sv
// Valid/ready request channel with a packed payload.
// Used for both requester-side and dcache-side request ports.
interface dcache_port_arbiter_if #(
  parameter int ReqWidth = 200
);
  logic                valid;
  logic                ready;
  logic [ReqWidth-1:0] payload;

  modport master (
    output valid,
    output payload,
    input  ready
  );

  modport slave (
    input  valid,
    input  payload,
    output ready
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing the dcache port between two requesters.
// An in-order ID FIFO routes each completion back to its issuer.
module dcache_port_arbiter #(
  parameter int ReqWidth       = 200,
  parameter int MaxOutstanding = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  dcache_port_arbiter_if.slave          req0,
  dcache_port_arbiter_if.slave          req1,
  dcache_port_arbiter_if.master         dc_req,
  output logic                          resp0_valid_o,
  output logic                          resp1_valid_o,
  output logic                          ex0_valid_o,
  output logic                          ex1_valid_o,
  input  logic                          dc_resp_valid_i,
  input  logic                          dc_ex_valid_i,
  output logic [$clog2(MaxOutstanding):0] outstanding_o,
  output logic                          err_o
);

  localparam int PtrW = $clog2(MaxOutstanding);
  localparam int CntW = PtrW + 1;

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } state_e;

  state_e              state_q, state_d;
  logic                lock_id_q, lock_id_d;
  logic                rr_q, rr_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [MaxOutstanding-1:0] id_q;

  logic grant;
  logic win_valid;
  logic full;
  logic empty;
  logic dc_valid;
  logic hs;
  logic comp;
  logic pop;
  logic head;
  logic lock_drop;

  always_comb begin
    grant = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant = lock_id_q;
    end else if (req0.valid && req1.valid) begin
      grant = rr_q;
    end else begin
      grant = req1.valid;
    end
  end

  assign win_valid = grant ? req1.valid : req0.valid;
  assign full      = cnt_q == CntW'(MaxOutstanding);
  assign empty     = cnt_q == '0;
  assign dc_valid  = win_valid && !full && !rst_i;
  assign hs        = dc_valid && dc_req.ready;
  assign comp      = dc_resp_valid_i || dc_ex_valid_i;
  assign pop       = comp && !empty;
  assign head      = id_q[rptr_q];

  assign dc_req.valid   = dc_valid;
  assign dc_req.payload = grant ? req1.payload : req0.payload;
  assign req0.ready     = !grant && dc_req.ready && !full && !rst_i;
  assign req1.ready     = grant && dc_req.ready && !full && !rst_i;

  // Exception takes precedence when both completion strobes collide
  assign resp0_valid_o = pop && !dc_ex_valid_i && !head;
  assign resp1_valid_o = pop && !dc_ex_valid_i && head;
  assign ex0_valid_o   = pop && dc_ex_valid_i && !head;
  assign ex1_valid_o   = pop && dc_ex_valid_i && head;

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    lock_drop = 1'b0;
    unique case (state_q)
      ST_OPEN: begin
        if (dc_valid && !dc_req.ready) begin
          state_d   = ST_LOCKED;
          lock_id_d = grant;
        end
      end
      ST_LOCKED: begin
        if (!win_valid) begin
          state_d   = ST_OPEN;
          lock_drop = 1'b1;
        end else if (hs) begin
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_OPEN;
    endcase
  end

  always_comb begin
    rr_d  = hs ? !grant : rr_q;
    cnt_d = cnt_q + CntW'(hs) - CntW'(pop);
    err_d = err_q || lock_drop
          || (comp && empty)
          || (dc_resp_valid_i && dc_ex_valid_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_OPEN;
      lock_id_q <= 1'b0;
      rr_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      if (hs) begin
        id_q[wptr_q] <= grant;
        wptr_q       <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter.
// Directed sequences; a negedge monitor checks grants and completions.
module tb_dcache_port_arbiter;

  localparam int W = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resp_i = 1'b0;
  logic ex_i = 1'b0;
  logic resp0, resp1, ex0, ex1;
  logic [2:0] outst;
  logic err;

  int checks = 0;
  int errors = 0;

  dcache_port_arbiter_if #(.ReqWidth(W)) r0 ();
  dcache_port_arbiter_if #(.ReqWidth(W)) r1 ();
  dcache_port_arbiter_if #(.ReqWidth(W)) dcq ();

  dcache_port_arbiter #(
    .ReqWidth(W),
    .MaxOutstanding(4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req0           (r0.slave),
    .req1           (r1.slave),
    .dc_req         (dcq.master),
    .resp0_valid_o  (resp0),
    .resp1_valid_o  (resp1),
    .ex0_valid_o    (ex0),
    .ex1_valid_o    (ex1),
    .dc_resp_valid_i(resp_i),
    .dc_ex_valid_i  (ex_i),
    .outstanding_o  (outst),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [W-1:0] pl;
  } gexp_t;

  typedef struct packed {
    logic ex;
    logic id;
  } cexp_t;

  gexp_t gq[$];
  cexp_t cq[$];
  gexp_t g;
  cexp_t c;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int tag);
    logic [W-1:0] v;
    v = W'(tag);
    return (v << 120) | (v << 40) | v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_exp(input logic id, input logic [W-1:0] pl);
    gexp_t e;
    e.id = id;
    e.pl = pl;
    gq.push_back(e);
  endtask

  task automatic comp_exp(input logic ex, input logic id);
    cexp_t e;
    e.ex = ex;
    e.id = id;
    cq.push_back(e);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    r0.valid  = 1'b0;
    r1.valid  = 1'b0;
    dcq.ready = 1'b0;
    resp_i    = 1'b0;
    ex_i      = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (dcq.valid && dcq.ready) begin
      if (gq.size() == 0) begin
        chk("grant_unexpected", 256'(gq.size()), 256'd1);
      end else begin
        g = gq.pop_front();
        chk("grant_ready", 256'({r0.ready, r1.ready}),
            g.id ? 256'd1 : 256'd2);
        chk("grant_payload", 256'(dcq.payload), 256'(g.pl));
      end
    end
    if (resp0 || resp1 || ex0 || ex1) begin
      if (cq.size() == 0) begin
        chk("comp_unexpected", 256'(cq.size()), 256'd1);
      end else begin
        c = cq.pop_front();
        chk("comp_route", 256'({ex0, ex1, resp0, resp1}),
            c.ex ? (c.id ? 256'd4 : 256'd8)
                 : (c.id ? 256'd1 : 256'd2));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    r0.valid   = 1'b0;
    r1.valid   = 1'b0;
    r0.payload = '0;
    r1.payload = '0;
    dcq.ready  = 1'b0;

    // single requester, reset-state checks
    tick();
    r0.valid   = 1'b1;
    r0.payload = mk(1);
    dcq.ready  = 1'b1;
    #1;
    chk("rst_dc_valid", 256'(dcq.valid), 256'd0);
    chk("rst_r0_ready", 256'(r0.ready), 256'd0);
    chk("rst_outst", 256'(outst), 256'd0);
    chk("rst_err", 256'(err), 256'd0);
    rst = 1'b0;
    issue_exp(1'b0, mk(1));
    #1;
    chk("t1_r0_ready", 256'(r0.ready), 256'd1);
    chk("t1_outst0", 256'(outst), 256'd0);
    tick();
    r0.valid = 1'b0;
    #1;
    chk("t1_outst1", 256'(outst), 256'd1);
    tick();
    resp_i = 1'b1;
    comp_exp(1'b0, 1'b0);
    #1;
    chk("t1_resp0", 256'(resp0), 256'd1);
    chk("t1_resp1", 256'(resp1), 256'd0);
    tick();
    resp_i = 1'b0;
    #1;
    chk("t1_outst_end", 256'(outst), 256'd0);

    // contention: grants 0,1,0,1
    do_reset();
    dcq.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r0.valid   = 1'b1;
      r1.valid   = 1'b1;
      r0.payload = mk(16 + k);
      r1.payload = mk(32 + k);
      resp_i     = (k >= 1);
      if (k >= 1) comp_exp(1'b0, 1'((k - 1) % 2));
      issue_exp(1'((k % 2)),
                (k % 2) ? mk(32 + k) : mk(16 + k));
      tick();
    end
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    resp_i   = 1'b1;
    comp_exp(1'b0, 1'b1);
    tick();
    resp_i = 1'b0;
    #1;
    chk("t2_outst_end", 256'(outst), 256'd0);

    // backpressure lock on requester 1
    do_reset();
    dcq.ready  = 1'b0;
    r1.valid   = 1'b1;
    r1.payload = mk(48);
    r0.payload = mk(64);
    #1;
    chk("t3_valid", 256'(dcq.valid), 256'd1);
    chk("t3_pl0", 256'(dcq.payload), 256'(mk(48)));
    tick();
    r0.valid = 1'b1;
    #1;
    chk("t3_pl1", 256'(dcq.payload), 256'(mk(48)));
    chk("t3_r0_ready", 256'(r0.ready), 256'd0);
    tick();
    #1;
    chk("t3_pl2", 256'(dcq.payload), 256'(mk(48)));
    tick();
    dcq.ready = 1'b1;
    issue_exp(1'b1, mk(48));
    #1;
    chk("t3_r1_ready", 256'(r1.ready), 256'd1);
    tick();
    r1.valid = 1'b0;
    issue_exp(1'b0, mk(64));
    #1;
    chk("t3_r0_accept", 256'(r0.ready), 256'd1);
    tick();
    r0.valid  = 1'b0;
    dcq.ready = 1'b0;
    resp_i    = 1'b1;
    comp_exp(1'b0, 1'b1);
    tick();
    comp_exp(1'b0, 1'b0);
    tick();
    resp_i = 1'b0;
    #1;
    chk("t3_outst_end", 256'(outst), 256'd0);
    chk("t3_err", 256'(err), 256'd0);

    // full FIFO blocks the fifth request
    do_reset();
    dcq.ready = 1'b1;
    r0.valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r0.payload = mk(80 + k);
      issue_exp(1'b0, mk(80 + k));
      tick();
    end
    r0.payload = mk(84);
    #1;
    chk("t4_outst_full", 256'(outst), 256'd4);
    chk("t4_valid_full", 256'(dcq.valid), 256'd0);
    chk("t4_ready_full", 256'(r0.ready), 256'd0);
    tick();
    resp_i = 1'b1;
    comp_exp(1'b0, 1'b0);
    #1;
    chk("t4_valid_pop", 256'(dcq.valid), 256'd0);
    tick();
    resp_i = 1'b0;
    issue_exp(1'b0, mk(84));
    #1;
    chk("t4_valid_after", 256'(dcq.valid), 256'd1);
    chk("t4_outst3", 256'(outst), 256'd3);
    tick();
    r0.valid = 1'b0;
    resp_i   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      comp_exp(1'b0, 1'b0);
      tick();
    end
    resp_i = 1'b0;
    #1;
    chk("t4_outst_end", 256'(outst), 256'd0);

    // exception routing
    do_reset();
    dcq.ready  = 1'b1;
    r1.valid   = 1'b1;
    r1.payload = mk(96);
    issue_exp(1'b1, mk(96));
    tick();
    r1.valid   = 1'b0;
    r0.valid   = 1'b1;
    r0.payload = mk(97);
    issue_exp(1'b0, mk(97));
    tick();
    r0.valid = 1'b0;
    ex_i     = 1'b1;
    comp_exp(1'b1, 1'b1);
    #1;
    chk("t5_ex1", 256'(ex1), 256'd1);
    tick();
    ex_i   = 1'b0;
    resp_i = 1'b1;
    comp_exp(1'b0, 1'b0);
    #1;
    chk("t5_resp0", 256'(resp0), 256'd1);
    tick();
    resp_i = 1'b0;
    #1;
    chk("t5_err", 256'(err), 256'd0);
    chk("t5_outst", 256'(outst), 256'd0);

    // completion with empty FIFO
    do_reset();
    resp_i = 1'b1;
    #1;
    chk("t6_no_pulse", 256'({resp0, resp1, ex0, ex1}), 256'd0);
    tick();
    resp_i = 1'b0;
    #1;
    chk("t6_err_empty", 256'(err), 256'd1);
    chk("t6_outst", 256'(outst), 256'd0);

    // resp and ex together
    do_reset();
    #1;
    chk("t6_err_cleared", 256'(err), 256'd0);
    dcq.ready  = 1'b1;
    r0.valid   = 1'b1;
    r0.payload = mk(112);
    issue_exp(1'b0, mk(112));
    tick();
    r0.valid = 1'b0;
    resp_i   = 1'b1;
    ex_i     = 1'b1;
    comp_exp(1'b1, 1'b0);
    #1;
    chk("t6_ex0", 256'(ex0), 256'd1);
    chk("t6_resp0_sup", 256'(resp0), 256'd0);
    tick();
    resp_i = 1'b0;
    ex_i   = 1'b0;
    #1;
    chk("t6_err_both", 256'(err), 256'd1);
    chk("t6_outst_both", 256'(outst), 256'd0);

    // reset mid-stream
    r0.valid   = 1'b1;
    r0.payload = mk(113);
    issue_exp(1'b0, mk(113));
    tick();
    r0.valid = 1'b0;
    #1;
    chk("t6_outst_inflight", 256'(outst), 256'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outst", 256'(outst), 256'd0);
    chk("t6_rst_err", 256'(err), 256'd0);
    tick();
    rst    = 1'b0;
    resp_i = 1'b1;
    #1;
    chk("t6_post_rst_pulse", 256'({resp0, resp1, ex0, ex1}), 256'd0);
    tick();
    resp_i = 1'b0;
    #1;
    chk("t6_post_rst_err", 256'(err), 256'd1);

    tick();
    chk("grant_q_empty", 256'(gq.size()), 256'd0);
    chk("comp_q_empty", 256'(cq.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
